// File: rtl/piso_tx.sv
//==============================================================================
// piso_tx
//------------------------------------------------------------------------------
// Parallel-in / serial-out frame transmitter. A WIDTH-bit word is accepted over
// a valid/ready handshake and shifted out on a single serial line as:
//
//   start (0) | d0 .. d(WIDTH-1) (LSB first) | [even parity] | stop (1)
//
// Each bit is held for CLKS_PER_BIT clock cycles. The serial line is a flop
// that only changes on the rising edge of c. A receiver that captures on the
// falling edge therefore samples every bit in the middle of its cycle.
//
// Optional feature:
//   PISO_TX_PARITY_EN  when defined, an even-parity bit (XOR of the accepted
//                      word) is sent between the last data bit and the stop
//                      bit. When undefined, DATA goes straight to STOP.
//
// Parameters:
//   WIDTH         data bits per frame (>= 1)
//   CLKS_PER_BIT  clock cycles each serial bit is held (>= 1)
//
// Ports:
//   c           in   clock, all state changes on the rising edge
//   r           in   synchronous active-high reset
//   din         in   parallel word, sampled only on an accepted load
//   load_valid  in   producer has a word on din
//   load_ready  out  block can accept a word this cycle
//   q           out  registered serial line, idles high
//   busy        out  a frame is in progress
//   done        out  one-cycle pulse in the idle cycle after the stop bit
//==============================================================================
module piso_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             c,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             busy,
  output logic             done
);

  // Counter widths never drop below one bit, so the degenerate
  // CLKS_PER_BIT=1 and WIDTH=1 builds still get a legal vector.
  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (WIDTH > 1)        ? $clog2(WIDTH)        : 1;

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [TICK_W-1:0]  tick_cnt;
  logic [TICK_W-1:0]  tick_cnt_next;
  logic [IDX_W-1:0]   bit_idx;
  logic [IDX_W-1:0]   bit_idx_next;
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   shift_next;
  logic               q_next;
  logic               done_next;
  logic               bit_end;

`ifdef PISO_TX_PARITY_EN
  logic               parity_bit;
  logic               parity_next;
`endif

  // Status outputs are decoded straight from the state register. Reset is
  // folded into load_ready so a producer never sees a handshake that the
  // reset branch of the state register would throw away.
  assign load_ready = (state == IDLE) && !r;
  assign busy       = (state != IDLE);

  // The current bit has been held long enough once the tick counter reaches
  // its last value.
  assign bit_end = (tick_cnt == LAST_TICK);

  // Next-state logic. The serial line value is computed from the *next* state
  // so that it is registered together with the state. This makes q fall on
  // the very edge that accepts a word and keeps q glitch-free.
  always_comb begin
    state_next    = state;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;
    done_next     = 1'b0;
    tick_cnt_next = tick_cnt;
    q_next        = 1'b1;
`ifdef PISO_TX_PARITY_EN
    parity_next   = parity_bit;
`endif

    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          state_next   = START;
          shift_next   = din;
          bit_idx_next = '0;
`ifdef PISO_TX_PARITY_EN
          parity_next  = ^din;
`endif
        end
      end

      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end

      DATA: begin
        // The shifter always presents the bit being sent in position 0.
        // Shifting at the end of each bit period lines up the next bit.
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx == LAST_BIT) begin
            bit_idx_next = '0;
`ifdef PISO_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end

`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // The tick counter restarts at every bit boundary. Consecutive data bits
    // stay in DATA, so a state change alone would not restart it.
    if (bit_end || (state_next != state)) begin
      tick_cnt_next = '0;
    end else if (state != IDLE) begin
      tick_cnt_next = tick_cnt + 1'b1;
    end

    case (state_next)
      START:   q_next = 1'b0;
      DATA:    q_next = shift_next[0];
`ifdef PISO_TX_PARITY_EN
      PARITY:  q_next = parity_next;
`endif
      default: q_next = 1'b1;
    endcase
  end

  // State register. Reset takes priority in every state. An aborted frame
  // returns the line to idle-high immediately and never raises done.
  always_ff @(posedge c) begin
    if (r) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      q         <= 1'b1;
      done      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      q         <= q_next;
      done      <= done_next;
`ifdef PISO_TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
//==============================================================================
// tb_piso_tx
//------------------------------------------------------------------------------
// Self-checking bench for piso_tx. Two instances share the clock, reset and
// din: dut1 holds each bit for one cycle and dut3 holds each bit for three
// cycles. Each instance has its own load_valid. Expected serial frames come
// from a constant table and from a small frame model built from the framing
// rules. The bench compiles with or without PISO_TX_PARITY_EN, matching the
// RTL build.
//==============================================================================
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       c;
  logic       r;
  logic [7:0] din;
  logic       lv1, lv3;
  logic       ready1, ready3;
  logic       q1, q3;
  logic       busy1, busy3;
  logic       done1, done3;

  int checks = 0;
  int errors = 0;

  bit expBits[$];

  typedef struct {
    logic [7:0]  din;
    logic [10:0] frame;   // time order: frame[nbits-1] is sent first
    int          nbits;
    int          inst;    // 1 -> dut1, 3 -> dut3
  } vec_t;

  vec_t vecs[7];

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .c(c), .r(r), .din(din), .load_valid(lv1), .load_ready(ready1),
    .q(q1), .busy(busy1), .done(done1)
  );

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(3)) dut3 (
    .c(c), .r(r), .din(din), .load_valid(lv3), .load_ready(ready3),
    .q(q3), .busy(busy3), .done(done3)
  );

  // Free-running clock, 10 time units per cycle.
  initial c = 1'b0;
  always #5 c = ~c;

  // Watchdog so that the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic qOf(input int inst);
    return (inst == 3) ? q3 : q1;
  endfunction

  function automatic logic busyOf(input int inst);
    return (inst == 3) ? busy3 : busy1;
  endfunction

  function automatic logic doneOf(input int inst);
    return (inst == 3) ? done3 : done1;
  endfunction

  function automatic logic readyOf(input int inst);
    return (inst == 3) ? ready3 : ready1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  task automatic buildFrame(input logic [7:0] d);
    int ones;
    ones = 0;
    expBits.delete();
    expBits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      expBits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PAR_EN) expBits.push_back((ones % 2) == 1);
    expBits.push_back(1'b1);
  endtask

  // Present a word while idle and let the next rising edge accept it.
  // Returns just after the accept edge, with load_valid dropped.
  task automatic applyStimulus(input int inst, input logic [7:0] d);
    @(posedge c); #1;
    din = d;
    if (inst == 3) lv3 = 1'b1; else lv1 = 1'b1;
    @(negedge c);
    checkOutput($sformatf("pre_ready_i%0d", inst), readyOf(inst), 1);
    checkOutput($sformatf("pre_busy_i%0d", inst),  busyOf(inst), 0);
    checkOutput($sformatf("pre_done_i%0d", inst),  doneOf(inst), 0);
    checkOutput($sformatf("pre_q_i%0d", inst),     qOf(inst), 1);
    @(posedge c); #1;
    lv1 = 1'b0;
    lv3 = 1'b0;
    din = 8'($urandom);
  endtask

  // Check a whole frame from the cycle after the accept edge through the done
  // cycle. The call ends at the falling edge inside the done cycle.
  task automatic checkFrame(input int inst, input int cpb, input bit scramble,
                            input int swapAt, input logic [7:0] swapVal);
    int n;
    n = expBits.size();
    for (int t = 0; t < n * cpb; t++) begin
      @(negedge c);
      checkOutput($sformatf("q_i%0d_bit%0d_cyc%0d", inst, t / cpb, t), qOf(inst), expBits[t / cpb]);
      checkOutput($sformatf("busy_i%0d_cyc%0d", inst, t), busyOf(inst), 1);
      checkOutput($sformatf("done_i%0d_cyc%0d", inst, t), doneOf(inst), 0);
      if (scramble) din = 8'($urandom);
      if (t == swapAt) din = swapVal;
    end
    @(negedge c);
    checkOutput($sformatf("done_pulse_i%0d", inst), doneOf(inst), 1);
    checkOutput($sformatf("done_busy_i%0d", inst),  busyOf(inst), 0);
    checkOutput($sformatf("done_ready_i%0d", inst), readyOf(inst), 1);
    checkOutput($sformatf("done_q_i%0d", inst),     qOf(inst), 1);
  endtask

  task automatic idleCycles(input int inst, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge c);
      checkOutput($sformatf("idle_q_i%0d", inst),    qOf(inst), 1);
      checkOutput($sformatf("idle_busy_i%0d", inst), busyOf(inst), 0);
      checkOutput($sformatf("idle_done_i%0d", inst), doneOf(inst), 0);
    end
  endtask

  initial begin
    logic [7:0] d;
    int         inst;

`ifdef PISO_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b01010010101, 11, 1};
    vecs[1] = '{8'h07, 11'b01110000011, 11, 1};
    vecs[2] = '{8'h00, 11'b00000000001, 11, 1};
    vecs[3] = '{8'hFF, 11'b01111111101, 11, 1};
    vecs[4] = '{8'h3C, 11'b00011110001, 11, 1};
    vecs[5] = '{8'h01, 11'b01000000011, 11, 3};
    vecs[6] = '{8'hA5, 11'b01010010101, 11, 3};
`else
    vecs[0] = '{8'hA5, {1'b0, 10'b0101001011}, 10, 1};
    vecs[1] = '{8'h07, {1'b0, 10'b0111000001}, 10, 1};
    vecs[2] = '{8'h00, {1'b0, 10'b0000000001}, 10, 1};
    vecs[3] = '{8'hFF, {1'b0, 10'b0111111111}, 10, 1};
    vecs[4] = '{8'h3C, {1'b0, 10'b0001111001}, 10, 1};
    vecs[5] = '{8'h01, {1'b0, 10'b0100000001}, 10, 3};
    vecs[6] = '{8'hA5, {1'b0, 10'b0101001011}, 10, 3};
`endif

    // Reset state
    r   = 1'b1;
    lv1 = 1'b0;
    lv3 = 1'b0;
    din = 8'h00;
    repeat (3) @(posedge c);
    @(negedge c);
    checkOutput("rst_q1", q1, 1);
    checkOutput("rst_busy1", busy1, 0);
    checkOutput("rst_done1", done1, 0);
    checkOutput("rst_ready1", ready1, 0);
    checkOutput("rst_q3", q3, 1);
    checkOutput("rst_ready3", ready3, 0);
    @(posedge c); #1;
    r = 1'b0;
    @(negedge c);
    checkOutput("post_rst_ready1", ready1, 1);
    checkOutput("post_rst_ready3", ready3, 1);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      expBits.delete();
      for (int t = 0; t < vecs[i].nbits; t++)
        expBits.push_back(vecs[i].frame[vecs[i].nbits - 1 - t]);
      applyStimulus(vecs[i].inst, vecs[i].din);
      checkFrame(vecs[i].inst, vecs[i].inst, 1'b1, -1, 8'h00);
      idleCycles(vecs[i].inst, 1);
    end

    // Back-to-back frames with load_valid held high. din switches mid-frame.
    // The second accept happens on the edge that ends the done cycle.
    $display("[TB] back-to-back sequence");
    @(posedge c); #1;
    din = 8'h3C;
    lv1 = 1'b1;
    @(posedge c); #1;
    buildFrame(8'h3C);
    checkFrame(1, 1, 1'b0, 3, 8'hC3);
    buildFrame(8'hC3);
    @(posedge c); #1;
    lv1 = 1'b0;
    din = 8'h00;
    checkFrame(1, 1, 1'b1, -1, 8'h00);
    idleCycles(1, 2);

    // Reset pulse during data bit 4
    $display("[TB] mid-frame reset sequence");
    buildFrame(8'hA5);
    applyStimulus(1, 8'hA5);
    for (int t = 0; t < 5; t++) begin
      @(negedge c);
      checkOutput($sformatf("abort_q_cyc%0d", t), q1, expBits[t]);
    end
    @(posedge c); #1;
    r = 1'b1;
    @(negedge c);
    checkOutput("abort_q_bit4", q1, expBits[5]);
    checkOutput("abort_ready_in_rst", ready1, 0);
    checkOutput("abort_busy_in_rst", busy1, 1);
    @(posedge c); #1;
    r = 1'b0;
    @(negedge c);
    checkOutput("abort_q_after", q1, 1);
    checkOutput("abort_busy_after", busy1, 0);
    checkOutput("abort_done_after", done1, 0);
    checkOutput("abort_ready_after", ready1, 1);
    idleCycles(1, 12);
    buildFrame(8'h5A);
    applyStimulus(1, 8'h5A);
    checkFrame(1, 1, 1'b1, -1, 8'h00);

    // load_valid asserted while reset is held: nothing is accepted
    $display("[TB] valid-during-reset sequence");
    @(posedge c); #1;
    r   = 1'b1;
    lv1 = 1'b1;
    lv3 = 1'b1;
    din = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge c);
      checkOutput("rstv_ready1", ready1, 0);
      checkOutput("rstv_ready3", ready3, 0);
      checkOutput("rstv_q1", q1, 1);
      checkOutput("rstv_q3", q3, 1);
      checkOutput("rstv_busy1", busy1, 0);
      checkOutput("rstv_busy3", busy3, 0);
    end
    @(posedge c); #1;
    r   = 1'b0;
    lv1 = 1'b0;
    lv3 = 1'b0;
    @(negedge c);
    checkOutput("rstv_ready1_after", ready1, 1);
    checkOutput("rstv_q1_after", q1, 1);
    checkOutput("rstv_busy1_after", busy1, 0);

    // Randomized frames on both instances, checked against the frame model
    $display("[TB] random frames");
    for (int f = 0; f < 16; f++) begin
      d    = 8'($urandom);
      inst = (f % 2 == 0) ? 1 : 3;
      idleCycles(inst, $urandom_range(0, 2));
      buildFrame(d);
      applyStimulus(inst, d);
      checkFrame(inst, inst, 1'b1, -1, 8'h00);
    end

    idleCycles(1, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out frame transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single serial line. The frame is a start bit, the data LSB first, an optional parity bit, and a stop bit. It is the driving end of the serial capture path. Serial output changes only on the rising edge of `c`, so downstream falling-edge flops sample each bit mid-cycle.

## Interface
Parameters:
- `WIDTH`, 8, data bits per frame; legal range ≥1.
- `CLKS_PER_BIT`, 1, clock cycles each serial bit is held; legal range ≥1.

Ports:
- `c`  in  1  clock; all state updates on the rising edge.
- `r`  in  1  reset; one clock, reset is synchronous and active-high.
- `din`  in  WIDTH  parallel word; sampled only on an accepted load.
- `load_valid`  in  1  producer has a word on `din`.
- `load_ready`  out  1  block can accept a word this cycle.
- `q`  out  1  serial line; registered; idle level 1.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- FSM states:
  - IDLE: `q`=1; `load_ready`=1.
  - START: `q`=0.
  - DATA: `q`=shift_reg[0]; the register shifts right after each bit period.
  - PARITY: present only with the macro.
  - STOP: `q`=1.
- Accept occurs when `load_valid && load_ready` is sampled at a rising edge.
  - On accept, `din` is copied into shift_reg and parity is computed from it.
  - The FSM goes to START.
- A bit-period counter of width `$clog2(CLKS_PER_BIT)` (minimum 1) counts 0..CLKS_PER_BIT-1 in each bit state.
  - The FSM advances when the counter reaches CLKS_PER_BIT-1.
  - The counter clears on every state change.
- A data-bit counter of width `$clog2(WIDTH)` (minimum 1) counts 0..WIDTH-1 in DATA.
  - DATA exits after bit WIDTH-1.
- STOP exits to IDLE and asserts `done` for exactly that one IDLE cycle.
- `load_ready` = (state==IDLE) && !r. It is combinational from registered state.
- `busy` = (state!=IDLE). It is combinational from registered state.
- `load_valid` and `din` are ignored while busy; a change to `din` mid-frame does not affect the frame.
- Reset (`r`=1 at a rising edge), in any state including mid-frame:
  - Next state is IDLE, with `q`=1, `busy`=0 and `done`=0.
  - Counters and shift_reg are cleared.
  - No `done` is produced for an aborted frame.
  - While `r`=1, `load_ready`=0 and no load is accepted, even if `load_valid`=1.
- Reset values: `q`=1, `busy`=0, `done`=0, `load_ready`=0 during reset and 1 in the first cycle after reset.

## Timing
- Accept at edge k: from edge k, `q`=0 (start) for CLKS_PER_BIT cycles.
  - Then d0..d(WIDTH-1), each held CLKS_PER_BIT cycles.
  - Then parity (if enabled), held CLKS_PER_BIT cycles.
  - Then stop=1, held CLKS_PER_BIT cycles.
- Frame length N = WIDTH+2, or WIDTH+3 with parity.
- `busy` is high for exactly N×CLKS_PER_BIT cycles.
- `done` is high for 1 cycle immediately after, coincident with `load_ready`=1.
- Latency from accept edge to first start-bit cycle: 0; `q` falls at the accept edge itself.
- Back-to-back: with `load_valid` held high, the next accept occurs at the edge ending the `done` cycle.
  - Frames are therefore separated by exactly one idle cycle (`q`=1).
  - Throughput is one word per N×CLKS_PER_BIT+1 cycles.

## Configuration
- `PISO_TX_PARITY_EN` defined:
  - PARITY state is compiled in, between DATA and STOP.
  - The parity bit is even parity: XOR of all `din` bits, captured at accept.
  - N = WIDTH+3.
- Undefined:
  - No parity state or logic; DATA goes directly to STOP.
  - N = WIDTH+2.

## Test plan
- WIDTH=8, CLKS_PER_BIT=1, no macro, `din`=8'hA5 accepted -> `q` = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; `busy` high 10 cycles; `done` pulses on cycle 11.
- Macro defined, `din`=8'h07 -> `q` = 0,1,1,1,0,0,0,0,0,1,1 (parity=1); `din`=8'hA5 -> parity bit 0.
- CLKS_PER_BIT=3, `din`=8'h01 -> start held 3 cycles, then d0=1 held 3 cycles, then 21 cycles of 0, then stop held 3 cycles; `busy`=30 cycles.
- `load_valid` held high with `din` switching 8'h3C->8'hC3 mid-frame -> first frame carries 8'h3C; second accept occurs on the `done` cycle with exactly one `q`=1 idle cycle between the stop bit and the next start bit.
- `r` pulsed for 1 cycle during data bit 4 -> `q`=1 and `busy`=0 at the next edge; no `done`; `load_ready`=0 while `r`=1, then 1; a new word sent afterwards serializes correctly.
- `load_valid`=1 while `r`=1 -> no accept; `q` stays 1 throughout.
